mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the IF fetch port and the MEM data port.
// state  | meaning: IDLE wait for request (DM first) | ACCESS ram_ce held | DONE ack pulse
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        stall_if_o,
  output logic        stall_dm_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   if_hold_q, if_hold_d;
  logic [31:0]   dm_hold_q, dm_hold_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      cnt_q     <= '0;
      rdata_q   <= 32'd0;
      if_hold_q <= 32'd0;
      dm_hold_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      if_hold_q <= if_hold_d;
      dm_hold_q <= dm_hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    if_hold_d = if_hold_q;
    dm_hold_d = dm_hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (dm_req_i) begin
          grant_d = 1'b1;
          we_d    = dm_we_i;
          sel_d   = dm_sel_i;
          addr_d  = dm_addr_i;
          wdata_d = dm_wdata_i;
          cnt_d   = CW'(MEM_LATENCY - 1);
          // Zero byte lanes means the MEM stage rejected a misaligned access.
          if (dm_sel_i == 4'd0) begin
            rdata_d = 32'd0;
            state_d = S_DONE;
          end else begin
            state_d = S_ACCESS;
          end
        end else if (if_req_i) begin
          grant_d = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'b1111;
          addr_d  = if_addr_i;
          wdata_d = 32'd0;
          cnt_d   = CW'(MEM_LATENCY - 1);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (!we_q) rdata_d = ram_rdata_i;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (grant_q) dm_hold_d = rdata_q;
        else         if_hold_d = rdata_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_sel_o   = 4'd0;
    ram_addr_o  = 32'd0;
    ram_wdata_o = 32'd0;
    if (state_q == S_ACCESS) begin
      ram_ce_o    = 1'b1;
      ram_we_o    = we_q;
      ram_sel_o   = sel_q;
      ram_addr_o  = addr_q;
      ram_wdata_o = we_q ? wdata_q : 32'd0;
    end
  end

  assign if_ack_o   = (state_q == S_DONE) && !grant_q;
  assign dm_ack_o   = (state_q == S_DONE) &&  grant_q;
  assign if_rdata_o = if_ack_o ? rdata_q : if_hold_q;
  assign dm_rdata_o = dm_ack_o ? rdata_q : dm_hold_q;
  assign stall_if_o = if_req_i & ~if_ack_o;
  assign stall_dm_o = dm_req_i & ~dm_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency-2 instance for most scenarios,
// latency-1 instance for the single-ACCESS-cycle case.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_sel;
  logic [31:0] if_rdata, dm_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        if_ack, dm_ack, stall_if, stall_dm, ram_ce, ram_we;
  logic [3:0]  ram_sel;

  logic        b_if_req, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
  logic [3:0]  b_dm_sel;
  logic [31:0] b_if_rdata, b_dm_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic        b_if_ack, b_dm_ack, b_stall_if, b_stall_dm, b_ram_ce, b_ram_we;
  logic [3:0]  b_ram_sel;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h100: return 32'hDEADBEEF;
      32'h040: return 32'h11223344;
      32'h008: return 32'hCAFEF00D;
      default: return a ^ 32'h5A00_0000;
    endcase
  endfunction

  assign ram_rdata   = mem_model(ram_addr);
  assign b_ram_rdata = mem_model(b_ram_addr);

  mem_port_arbiter #(.MEM_LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_sel_i(dm_sel), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack),
    .stall_if_o(stall_if), .stall_dm_o(stall_dm),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_sel_o(ram_sel), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  mem_port_arbiter #(.MEM_LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_rdata_o(b_if_rdata), .if_ack_o(b_if_ack),
    .dm_req_i(b_dm_req), .dm_we_i(b_dm_we), .dm_sel_i(b_dm_sel), .dm_addr_i(b_dm_addr),
    .dm_wdata_i(b_dm_wdata), .dm_rdata_o(b_dm_rdata), .dm_ack_o(b_dm_ack),
    .stall_if_o(b_stall_if), .stall_dm_o(b_stall_dm),
    .ram_ce_o(b_ram_ce), .ram_we_o(b_ram_we), .ram_sel_o(b_ram_sel), .ram_addr_o(b_ram_addr),
    .ram_wdata_o(b_ram_wdata), .ram_rdata_i(b_ram_rdata)
  );

  task automatic test_reset();
    rst = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_sel = 0; dm_addr = 0; dm_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0; b_dm_sel = 0; b_dm_addr = 0; b_dm_wdata = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ram_ce, ram_we, ram_sel, ram_addr, ram_wdata, if_ack, dm_ack, if_rdata, dm_rdata} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got ce=%b ack=%b/%b ifr=%h dmr=%h exp all 0",
                        ram_ce, if_ack, dm_ack, if_rdata, dm_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_if_read();
    if_req = 1; if_addr = 32'h100;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ram_ce !== (k == 1 || k == 2)) begin
        n_bad++; $display("FAIL if_read_ce k=%0d got %b exp %b", k, ram_ce, (k == 1 || k == 2));
      end
      n_cmp++;
      if (if_ack !== (k == 3)) begin
        n_bad++; $display("FAIL if_read_ack k=%0d got %b exp %b", k, if_ack, (k == 3));
      end
      n_cmp++;
      if (stall_if !== (k < 3)) begin
        n_bad++; $display("FAIL if_read_stall k=%0d got %b exp %b", k, stall_if, (k < 3));
      end
      if (k == 1) begin
        n_cmp++;
        if (ram_addr !== 32'h100 || ram_sel !== 4'hF || ram_we !== 1'b0) begin
          n_bad++; $display("FAIL if_read_bus got addr=%h sel=%b we=%b exp 100/1111/0", ram_addr, ram_sel, ram_we);
        end
      end
      if (k >= 3) begin
        n_cmp++;
        if (if_rdata !== 32'hDEADBEEF) begin
          n_bad++; $display("FAIL if_read_rdata k=%0d got %h exp deadbeef", k, if_rdata);
        end
      end
      if (k == 3) if_req = 0;
    end
  endtask

  task automatic test_reset_mid();
    if_req = 1; if_addr = 32'h100;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ram_ce !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_in_access got ce=%b exp 1", ram_ce);
    end
    rst = 1; if_req = 0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({ram_ce, ram_we, ram_sel, ram_addr, if_ack, dm_ack, if_rdata, dm_rdata, stall_if} !== '0) begin
        n_bad++; $display("FAIL rstmid_outputs k=%0d got ce=%b addr=%h ack=%b ifr=%h exp all 0",
                          k, ram_ce, ram_addr, if_ack, if_rdata);
      end
    end
    rst = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (if_ack !== 1'b0 || ram_ce !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_no_ack k=%0d got ack=%b ce=%b exp 0/0", k, if_ack, ram_ce);
      end
    end
    if_req = 1; if_addr = 32'h8;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (if_ack !== (k == 3)) begin
        n_bad++; $display("FAIL rstmid_fresh_ack k=%0d got %b exp %b", k, if_ack, (k == 3));
      end
      if (k == 3) begin
        n_cmp++;
        if (if_rdata !== 32'hCAFEF00D) begin
          n_bad++; $display("FAIL rstmid_fresh_rdata got %h exp cafef00d", if_rdata);
        end
        if_req = 0;
      end
    end
  endtask

  task automatic test_simultaneous();
    dm_req = 1; dm_we = 0; dm_sel = 4'hF; dm_addr = 32'h40; dm_wdata = 32'hFFFF_FFFF;
    if_req = 1; if_addr = 32'h8;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ram_ce !== (k == 1 || k == 2 || k == 5 || k == 6)) begin
        n_bad++; $display("FAIL simul_ce k=%0d got %b", k, ram_ce);
      end
      n_cmp++;
      if (dm_ack !== (k == 3) || if_ack !== (k == 7)) begin
        n_bad++; $display("FAIL simul_ack k=%0d got dm=%b if=%b exp %b/%b", k, dm_ack, if_ack, (k == 3), (k == 7));
      end
      n_cmp++;
      if (stall_if !== (k < 7) || stall_dm !== (k < 3)) begin
        n_bad++; $display("FAIL simul_stall k=%0d got if=%b dm=%b exp %b/%b", k, stall_if, stall_dm, (k < 7), (k < 3));
      end
      if (k == 1) begin
        n_cmp++;
        if (ram_addr !== 32'h40 || ram_wdata !== 32'd0) begin
          n_bad++; $display("FAIL simul_dm_bus got addr=%h wdata=%h exp 40/0", ram_addr, ram_wdata);
        end
      end
      if (k == 5) begin
        n_cmp++;
        if (ram_addr !== 32'h8) begin
          n_bad++; $display("FAIL simul_if_bus got addr=%h exp 8", ram_addr);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if (dm_rdata !== 32'h11223344) begin
          n_bad++; $display("FAIL simul_dm_rdata got %h exp 11223344", dm_rdata);
        end
        dm_req = 0;
      end
      if (k == 7) begin
        n_cmp++;
        if (if_rdata !== 32'hCAFEF00D || dm_rdata !== 32'h11223344) begin
          n_bad++; $display("FAIL simul_if_rdata got if=%h dm=%h exp cafef00d/11223344", if_rdata, dm_rdata);
        end
        if_req = 0;
      end
    end
  endtask

  task automatic test_zero_sel();
    dm_req = 1; dm_we = 0; dm_sel = 4'h0; dm_addr = 32'h300;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ram_ce !== 1'b0) begin
        n_bad++; $display("FAIL zsel_ce k=%0d got %b exp 0", k, ram_ce);
      end
      n_cmp++;
      if (dm_ack !== (k == 1)) begin
        n_bad++; $display("FAIL zsel_ack k=%0d got %b exp %b", k, dm_ack, (k == 1));
      end
      if (k == 1) begin
        n_cmp++;
        if (dm_rdata !== 32'd0) begin
          n_bad++; $display("FAIL zsel_rdata got %h exp 0", dm_rdata);
        end
        dm_req = 0;
      end
    end
  endtask

  task automatic test_store();
    dm_req = 1; dm_we = 1; dm_sel = 4'b0100; dm_addr = 32'h202; dm_wdata = 32'h5A5A5A5A;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        n_cmp++;
        if (ram_ce !== 1 || ram_we !== 1 || ram_sel !== 4'b0100 || ram_addr !== 32'h202 || ram_wdata !== 32'h5A5A5A5A) begin
          n_bad++; $display("FAIL store_bus k=%0d got ce=%b we=%b sel=%b addr=%h wd=%h exp 1/1/0100/202/5a5a5a5a",
                            k, ram_ce, ram_we, ram_sel, ram_addr, ram_wdata);
        end
      end
      n_cmp++;
      if (dm_ack !== (k == 3)) begin
        n_bad++; $display("FAIL store_ack k=%0d got %b exp %b", k, dm_ack, (k == 3));
      end
      if (k >= 3) begin
        n_cmp++;
        if (dm_rdata !== 32'd0 || ram_ce !== 1'b0 || ram_we !== 1'b0) begin
          n_bad++; $display("FAIL store_after k=%0d got rdata=%h ce=%b we=%b exp 0/0/0", k, dm_rdata, ram_ce, ram_we);
        end
      end
      if (k == 3) dm_req = 0;
    end
    dm_we = 0;
  endtask

  task automatic test_stability();
    dm_req = 1; dm_we = 0; dm_sel = 4'hF; dm_addr = 32'h40;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        n_cmp++;
        if (ram_addr !== 32'h40 || ram_sel !== 4'hF || ram_we !== 1'b0) begin
          n_bad++; $display("FAIL stable_bus k=%0d got addr=%h sel=%b we=%b exp 40/1111/0", k, ram_addr, ram_sel, ram_we);
        end
      end
      if (k == 1) begin dm_addr = 32'h999; dm_sel = 4'b0011; dm_we = 1; end
      if (k == 3) begin
        n_cmp++;
        if (dm_ack !== 1'b1 || dm_rdata !== 32'h11223344) begin
          n_bad++; $display("FAIL stable_ack got ack=%b rdata=%h exp 1/11223344", dm_ack, dm_rdata);
        end
        dm_req = 0; dm_we = 0;
      end
    end
  endtask

  task automatic test_lat1();
    b_dm_req = 1; b_dm_we = 0; b_dm_sel = 4'hF; b_dm_addr = 32'h100;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (b_ram_ce !== (k == 1)) begin
        n_bad++; $display("FAIL lat1_ce k=%0d got %b exp %b", k, b_ram_ce, (k == 1));
      end
      n_cmp++;
      if (b_dm_ack !== (k == 2)) begin
        n_bad++; $display("FAIL lat1_ack k=%0d got %b exp %b", k, b_dm_ack, (k == 2));
      end
      if (k == 1) begin
        n_cmp++;
        if (b_ram_addr !== 32'h100) begin
          n_bad++; $display("FAIL lat1_addr got %h exp 100", b_ram_addr);
        end
        b_dm_addr = 32'h40;
      end
      if (k == 2) begin
        n_cmp++;
        if (b_dm_rdata !== 32'hDEADBEEF) begin
          n_bad++; $display("FAIL lat1_rdata got %h exp deadbeef", b_dm_rdata);
        end
        b_dm_req = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_reset_mid();
    test_simultaneous();
    test_zero_sel();
    test_store();
    test_stability();
    test_lat1();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
